// File: rtl/audio_pkg.sv
// Shared audio-path types and default widths for the synth output chain.
package audio_pkg;
    localparam int SLOT_W_DEF   = 32;
    localparam int SAMPLE_W_DEF = 16;

    typedef logic signed [15:0] sample_t;
endpackage

// File: rtl/audio_dac_serializer_if.sv
// Sample handshake between the effects chain (master) and the DAC serializer (slave).
interface audio_dac_serializer_if
    import audio_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF
);
    logic signed [SAMPLE_W-1:0] sample_in;
    logic                       sample_valid;
    logic                       sample_ready;

    modport master (output sample_in, output sample_valid, input  sample_ready);
    modport slave  (input  sample_in, input  sample_valid, output sample_ready);
endinterface

// File: rtl/audio_dac_serializer_bclk_gen.sv
// Bit-clock divider: BCLK toggles every CLK_DIV Clk cycles; fall flags the edge taking BCLK low.
module bclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic Clk,
    input  logic Reset,
    output logic BCLK,
    output logic fall
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] div_cnt;
    logic          wrap;

    assign wrap = (div_cnt == CW'(CLK_DIV - 1));
    // High during the cycle whose closing edge drives BCLK 1->0.
    assign fall = wrap & BCLK;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_cnt <= '0;
            BCLK    <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            BCLK    <= ~BCLK;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/audio_dac_serializer.sv
// I2S master output stage: buffers one mono sample, sends it on both slots, paces upstream via sample_req.
module audio_dac_serializer
    import audio_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int SLOT_W   = SLOT_W_DEF
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Enable,
    audio_dac_serializer_if.slave smp,
    output logic                  sample_req,
    output logic [7:0]            underrun_cnt,
    output logic                  BCLK,
    output logic                  LRCK,
    output logic                  DACDAT
);
    localparam int BW = $clog2(2 * SLOT_W);
    localparam int IW = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;

    logic                fall;
    logic [BW-1:0]       bit_cnt, bit_nxt, slot_b;
    logic [SAMPLE_W-1:0] hold, frame_reg, last_sample;
    logic                hold_full, latch, accept, dout;
    logic [IW-1:0]       idx;

    bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk (
        .Clk   (Clk),
        .Reset (Reset),
        .BCLK  (BCLK),
        .fall  (fall)
    );

    assign bit_nxt = (bit_cnt == BW'(2 * SLOT_W - 1)) ? '0 : bit_cnt + 1'b1;
    assign slot_b  = (bit_nxt >= BW'(SLOT_W)) ? bit_nxt - BW'(SLOT_W) : bit_nxt;
    assign latch   = fall && (bit_nxt == '0);
    assign accept  = smp.sample_valid && !hold_full;
    assign smp.sample_ready = !hold_full;

    // Slot bit 0 is the I2S delay bit; bits past the sample are zero padding.
    // At the latch edge slot_b is 0, so the old frame_reg is never shifted out.
    always_comb begin
        dout = 1'b0;
        idx  = '0;
        if (slot_b >= BW'(1) && slot_b <= BW'(SAMPLE_W)) begin
            idx  = IW'(SAMPLE_W - int'(slot_b));
            dout = frame_reg[idx];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            bit_cnt      <= '0;
            LRCK         <= 1'b0;
            DACDAT       <= 1'b0;
            sample_req   <= 1'b0;
            underrun_cnt <= '0;
            hold_full    <= 1'b0;
            hold         <= '0;
            frame_reg    <= '0;
            last_sample  <= '0;
        end else begin
            sample_req <= latch;
            if (fall) begin
                bit_cnt <= bit_nxt;
                LRCK    <= (bit_nxt >= BW'(SLOT_W));
                DACDAT  <= dout;
            end
            // Latch decides on the pre-edge holding state; a same-cycle accept waits a frame.
            if (latch) begin
                if (!Enable) begin
                    frame_reg <= '0;
                end else if (hold_full) begin
                    frame_reg   <= hold;
                    last_sample <= hold;
                    hold_full   <= 1'b0;
                end else begin
                    frame_reg <= last_sample;
                    if (underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 1'b1;
                end
            end
            if (accept) begin
                hold      <= smp.sample_in;
                hold_full <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed bench for audio_dac_serializer with a time-indexed reference model checked every cycle.
module tb_audio_dac_serializer;
    import audio_pkg::*;

    localparam int CD = 2, SW = 16, SL = 32;
    localparam int FR = 2 * SL * 2 * CD;

    logic       Clk = 1'b0, Reset = 1'b1, Enable = 1'b1;
    logic       sample_req, BCLK, LRCK, DACDAT;
    logic [7:0] underrun_cnt;

    audio_dac_serializer_if #(.SAMPLE_W(SW)) smp ();

    audio_dac_serializer #(.CLK_DIV(CD), .SAMPLE_W(SW), .SLOT_W(SL)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Enable       (Enable),
        .smp          (smp),
        .sample_req   (sample_req),
        .underrun_cnt (underrun_cnt),
        .BCLK         (BCLK),
        .LRCK         (LRCK),
        .DACDAT       (DACDAT)
    );

    always #5 Clk = ~Clk;

    int errors = 0, checks = 0;
    bit chk_en = 1'b0;

    // Model: everything is derived from Clk edges since reset plus the sample queue of depth one.
    int          m_t, m_und;
    bit          m_full, m_req;
    logic [SW-1:0] m_hold, m_last, m_frame;

    always @(posedge Clk) begin
        automatic int nt;
        automatic bit fl, lt, ac, full;
        automatic logic [SW-1:0] hold, last, frame;
        automatic int und;
        if (Reset) begin
            m_t <= 0; m_und <= 0; m_full <= 1'b0; m_req <= 1'b0;
            m_hold <= '0; m_last <= '0; m_frame <= '0;
        end else begin
            nt = m_t + 1;
            fl = (nt % (2 * CD) == 0);
            lt = fl && ((nt / (2 * CD)) % (2 * SL) == 0);
            ac = smp.sample_valid && !m_full;
            full = m_full; hold = m_hold; last = m_last; frame = m_frame; und = m_und;
            if (lt) begin
                if (!Enable) frame = '0;
                else if (full) begin frame = hold; last = hold; full = 1'b0; end
                else begin frame = last; if (und < 255) und = und + 1; end
            end
            if (ac) begin hold = smp.sample_in; full = 1'b1; end
            m_t <= nt; m_req <= lt; m_full <= full; m_hold <= hold;
            m_last <= last; m_frame <= frame; m_und <= und;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        automatic int n, bc, b;
        automatic logic ed;
        if (chk_en) begin
            n  = m_t / (2 * CD);
            bc = n % (2 * SL);
            b  = bc % SL;
            ed = (b >= 1 && b <= SW) ? m_frame[SW-b] : 1'b0;
            check("bclk",     64'(BCLK),             64'((m_t / CD) % 2));
            check("lrck",     64'(LRCK),             64'(bc >= SL));
            check("dacdat",   64'(DACDAT),           64'(ed));
            check("req",      64'(sample_req),       64'(m_req));
            check("ready",    64'(smp.sample_ready), 64'(!m_full));
            check("underrun", 64'(underrun_cnt),     64'(m_und));
        end
    end

    task automatic wait_req(output int cyc);
        cyc = 0;
        while (cyc < FR + 50) begin
            @(negedge Clk);
            cyc++;
            if (sample_req) return;
        end
        errors++; checks++;
        $display("FAIL wait_req: got no sample_req expected one within %0d cycles", cyc);
    endtask

    task automatic push(input sample_t d);
        automatic bit acc;
        smp.sample_in = d;
        smp.sample_valid = 1'b1;
        for (int n = 0; n < 2 * FR; n++) begin
            acc = smp.sample_ready;
            @(negedge Clk);
            if (acc) begin smp.sample_valid = 1'b0; return; end
        end
        smp.sample_valid = 1'b0;
        errors++; checks++;
        $display("FAIL push: got no accept expected one for %0h", d);
    endtask

    // Codec view: DACDAT per bit slot, first slot bit in the MSB.
    task automatic capture(output logic [63:0] f);
        f = '0;
        for (int j = 0; j < 2 * SL; j++) begin
            f[2*SL-1-j] = DACDAT;
            if (j < 2 * SL - 1) repeat (2 * CD) @(negedge Clk);
        end
    endtask

    initial begin
        automatic int c;
        automatic logic [63:0] f;
        smp.sample_in = '0;
        smp.sample_valid = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_bclk", 64'(BCLK), 64'(0));
        check("rst_ready", 64'(smp.sample_ready), 64'(1));
        check("rst_underrun", 64'(underrun_cnt), 64'(0));
        Reset = 1'b0;
        chk_en = 1'b1;

        // Idle: first latch one frame after reset, counted as an underrun.
        wait_req(c);
        check("first_req_cycles", 64'(c), 64'(256));
        check("idle_underrun", 64'(underrun_cnt), 64'(1));

        // 8001 framed both slots, then repeated without a push.
        push(16'h8001);
        wait_req(c); capture(f);
        check("frame_8001", f, 64'h40008000_40008000);
        check("underrun_8001", 64'(underrun_cnt), 64'(1));
        wait_req(c); capture(f);
        check("frame_8001_rpt", f, 64'h40008000_40008000);
        check("underrun_rpt", 64'(underrun_cnt), 64'(2));

        // A accepted, B held off until A is latched.
        push(16'h1234);
        smp.sample_in = 16'h5A5A; smp.sample_valid = 1'b1;
        check("b_held_ready", 64'(smp.sample_ready), 64'(0));
        push(16'h5A5A);
        wait_req(c); capture(f);
        check("frame_b", f, 64'h2D2D0000_2D2D0000);
        check("underrun_ab", 64'(underrun_cnt), 64'(2));

        // Mute with a full holding register.
        push(16'h7FFF);
        Enable = 1'b0;
        wait_req(c); capture(f);
        check("frame_mute", f, 64'h0);
        check("mute_underrun", 64'(underrun_cnt), 64'(2));
        check("mute_hold_kept", 64'(smp.sample_ready), 64'(0));
        Enable = 1'b1;
        wait_req(c); capture(f);
        check("frame_unmute", f, 64'h3FFF8000_3FFF8000);
        check("unmute_ready", 64'(smp.sample_ready), 64'(1));

        // Reset mid right slot with a sample pending.
        wait_req(c);
        push(16'h1357);
        repeat (160) @(negedge Clk);
        check("mid_right_lrck", 64'(LRCK), 64'(1));
        Reset = 1'b1;
        @(negedge Clk);
        check("mrst_bclk", 64'(BCLK), 64'(0));
        check("mrst_lrck", 64'(LRCK), 64'(0));
        check("mrst_dacdat", 64'(DACDAT), 64'(0));
        check("mrst_ready", 64'(smp.sample_ready), 64'(1));
        check("mrst_underrun", 64'(underrun_cnt), 64'(0));
        Reset = 1'b0;
        wait_req(c);
        check("post_rst_req_cycles", 64'(c), 64'(256));
        capture(f);
        check("post_rst_frame", f, 64'h0);
        check("post_rst_underrun", 64'(underrun_cnt), 64'(1));

        // Accept coincident with latch on empty holding: deferred one frame.
        wait_req(c);
        repeat (FR - 1) @(negedge Clk);
        push(16'h0F0F);
        check("coinc_req", 64'(sample_req), 64'(1));
        check("coinc_underrun", 64'(underrun_cnt), 64'(3));
        check("coinc_ready", 64'(smp.sample_ready), 64'(0));
        wait_req(c); capture(f);
        check("frame_deferred", f, 64'h07878000_07878000);
        check("deferred_underrun", 64'(underrun_cnt), 64'(3));

        // Long starvation saturates the underrun counter.
        for (int k = 0; k < 260; k++) wait_req(c);
        check("underrun_sat", 64'(underrun_cnt), 64'(255));

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
